// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 SCCB boot configuration sequencer.
// Frame layout is expressed in quarter-bit (QT) ticks counted from the engine's go pulse.
package ov7670_pkg;

    typedef enum logic [2:0] {
        S_CAM_RST = 3'd0,
        S_BOOT    = 3'd1,
        S_FETCH   = 3'd2,
        S_DECODE  = 3'd3,
        S_WRITE   = 3'd4,
        S_DELAY   = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [7:0]  DELAY_TAG = 8'hFF;
    localparam logic [15:0] END_WORD  = 16'hFFFF;

    // QT0-1 idle high, QT2-3 start (SIOD low under SIOC high), QT4-111 27 bits,
    // QT112-115 stop, QT116-119 bus-idle gap.
    localparam int unsigned QT_START_LOW    = 2;
    localparam int unsigned QT_BITS_FIRST   = 4;
    localparam int unsigned QT_STOP_FIRST   = 112;
    localparam int unsigned QT_STOP_RELEASE = 115;
    localparam int unsigned FRAME_QT        = 120;

    // Minimal bring-up table: soft reset, settle, RGB565 output.
    function automatic logic [15:0] default_table(input logic [7:0] idx);
        logic [15:0] word;
        case (idx)
            8'd0:    word = 16'h1280;
            8'd1:    word = 16'hFF0A;
            8'd2:    word = 16'h1204;
            8'd3:    word = 16'h1100;
            8'd4:    word = 16'h0C00;
            8'd5:    word = 16'h3E00;
            8'd6:    word = 16'h4010;
            8'd7:    word = 16'h8C00;
            8'd8:    word = 16'h3A04;
            default: word = END_WORD;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/sccb_write_engine.sv
// SCCB 3-phase write bit engine: quarter-tick divider, frame QT counter and registered pin drivers.
// The data line is only ever pulled low or released; it is never driven high.
module sccb_write_engine
    import ov7670_pkg::*;
#(
    parameter int unsigned QT = 250
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       go_i,
    input  logic [7:0] id_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] val_i,
    output logic       done_o,
    output logic       sioc_o,
    output logic       siod_o,
    output logic       siod_oe_o
);

    localparam int unsigned TW = (QT > 1) ? $clog2(QT) : 1;

    // Handshake: go_i is a 1-cycle request accepted only while idle (operands latched
    // that cycle); done_o is a 1-cycle pulse in the final tick of the frame gap.
    logic          active_q, active_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [6:0]    qidx_q, qidx_d;
    logic [23:0]   data_q, data_d;
    logic          sioc_q, siod_q, oe_q;
    logic          sioc_d, oe_d;
    logic          last_tick;
    logic [6:0]    rel;
    logic [4:0]    bit_n, pos, sel;
    logic [1:0]    phase;

    always_comb begin
        active_d  = active_q;
        tick_d    = tick_q;
        qidx_d    = qidx_q;
        data_d    = data_q;
        done_o    = 1'b0;
        last_tick = (tick_q == TW'(QT - 1));
        if (!active_q) begin
            if (go_i) begin
                active_d = 1'b1;
                tick_d   = '0;
                qidx_d   = '0;
                data_d   = {id_i, addr_i, val_i};
            end
        end else if (last_tick) begin
            tick_d = '0;
            if (qidx_q == 7'(FRAME_QT - 1)) begin
                active_d = 1'b0;
                done_o   = 1'b1;
            end else begin
                qidx_d = qidx_q + 7'd1;
            end
        end else begin
            tick_d = tick_q + TW'(1);
        end
    end

    // Pin decode of the current QT; each byte is followed by a released don't-care bit.
    always_comb begin
        sioc_d = 1'b1;
        oe_d   = 1'b0;
        rel    = qidx_q - 7'(QT_BITS_FIRST);
        bit_n  = rel[6:2];
        phase  = rel[1:0];
        if (bit_n >= 5'd18) begin
            pos = bit_n - 5'd18;
            sel = 5'd7 - pos;
        end else if (bit_n >= 5'd9) begin
            pos = bit_n - 5'd9;
            sel = 5'd15 - pos;
        end else begin
            pos = bit_n;
            sel = 5'd23 - pos;
        end
        if (active_q) begin
            if (qidx_q < 7'(QT_START_LOW)) begin
                oe_d = 1'b0;
            end else if (qidx_q < 7'(QT_BITS_FIRST)) begin
                oe_d = 1'b1;
            end else if (qidx_q < 7'(QT_STOP_FIRST)) begin
                sioc_d = (phase == 2'd1) || (phase == 2'd2);
                if (pos != 5'd8) begin
                    oe_d = ~data_q[sel];
                end
            end else if (qidx_q == 7'(QT_STOP_FIRST)) begin
                sioc_d = 1'b0;
                oe_d   = 1'b1;
            end else if (qidx_q < 7'(QT_STOP_RELEASE)) begin
                oe_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            tick_q   <= '0;
            qidx_q   <= '0;
            data_q   <= '0;
            sioc_q   <= 1'b1;
            siod_q   <= 1'b1;
            oe_q     <= 1'b0;
        end else begin
            active_q <= active_d;
            tick_q   <= tick_d;
            qidx_q   <= qidx_d;
            data_q   <= data_d;
            sioc_q   <= sioc_d;
            siod_q   <= ~oe_d;
            oe_q     <= oe_d;
        end
    end

    assign sioc_o    = sioc_q;
    assign siod_o    = siod_q;
    assign siod_oe_o = oe_q;

endmodule

// File: rtl/ov7670_sccb_config.sv
// OV7670 boot-time configuration sequencer: camera reset/boot wait, then one SCCB write
// per table word, with delay and end markers. A start pulse in DONE replays the table.
module ov7670_sccb_config
    import ov7670_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned SCCB_HZ      = 100_000,
    parameter logic [7:0]  SLAVE_ADDR   = 8'h42,
    parameter int unsigned ROM_AW       = 8,
    parameter int unsigned RESET_CYCLES = 100_000,
    parameter int unsigned BOOT_CYCLES  = 1_000_000,
    parameter int unsigned DELAY_UNIT   = 100_000
) (
    input  logic              sysclk,
    input  logic              sysreset,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              sioc,
    output logic              siod_o,
    output logic              siod_oe,
    output logic              cam_reset_n,
    output logic              cam_pwdn,
    output logic              busy,
    output logic              config_done
);

    localparam int unsigned QT        = CLK_HZ / (4 * SCCB_HZ);
    localparam int unsigned DELAY_MAX = 255 * DELAY_UNIT;
    localparam int unsigned WAIT_MAX  = (RESET_CYCLES > BOOT_CYCLES) ? RESET_CYCLES : BOOT_CYCLES;
    localparam int unsigned CNT_MAX   = (WAIT_MAX > DELAY_MAX) ? WAIT_MAX : DELAY_MAX;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [ROM_AW-1:0] ADDR_LAST = '1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ROM_AW-1:0] addr_q, addr_d;
    logic              cam_rst_n_q, cam_rst_n_d;
    logic              busy_q, done_q;
    logic              go, advance, eng_done;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        cam_rst_n_d = cam_rst_n_q;
        go          = 1'b0;
        advance     = 1'b0;
        case (state_q)
            S_CAM_RST: begin
                if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
                    state_d     = S_BOOT;
                    cnt_d       = '0;
                    cam_rst_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_BOOT: begin
                if (cnt_q == CNT_W'(BOOT_CYCLES - 1)) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                    addr_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (rom_data == END_WORD) begin
                    state_d = S_DONE;
                end else if (rom_data[15:8] == DELAY_TAG) begin
                    if (rom_data[7:0] == 8'd0) begin
                        advance = 1'b1;
                    end else begin
                        cnt_d   = CNT_W'(32'(rom_data[7:0]) * DELAY_UNIT);
                        state_d = S_DELAY;
                    end
                end else begin
                    go      = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: advance = eng_done;
            S_DELAY: begin
                // Loaded with xx*DELAY_UNIT, so the state lasts exactly that many cycles.
                if (cnt_q <= CNT_W'(1)) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (start) begin
                    addr_d  = '0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_CAM_RST;
        endcase
        // The table never wraps: the last address finishes the run.
        if (advance) begin
            if (addr_q == ADDR_LAST) begin
                state_d = S_DONE;
            end else begin
                addr_d  = addr_q + ROM_AW'(1);
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state_q     <= S_CAM_RST;
            cnt_q       <= '0;
            addr_q      <= '0;
            cam_rst_n_q <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            cam_rst_n_q <= cam_rst_n_d;
            busy_q      <= (state_d != S_DONE);
            done_q      <= (state_d == S_DONE);
        end
    end

    sccb_write_engine #(
        .QT(QT)
    ) u_engine (
        .clk_i     (sysclk),
        .rst_i     (sysreset),
        .go_i      (go),
        .id_i      (SLAVE_ADDR),
        .addr_i    (rom_data[15:8]),
        .val_i     (rom_data[7:0]),
        .done_o    (eng_done),
        .sioc_o    (sioc),
        .siod_o    (siod_o),
        .siod_oe_o (siod_oe)
    );

    assign rom_addr    = addr_q;
    assign cam_reset_n = cam_rst_n_q;
    assign cam_pwdn    = 1'b0;
    assign busy        = busy_q;
    assign config_done = done_q;

endmodule
